arbitro_rr_pesos: RTL and testbench
===================================

# arbitro_rr_pesos

Weighted round-robin arbiter that shares one downstream FIFO between four upstream class FIFOs: it pops one upstream FIFO at a time and pushes the words, with a one-cycle registered latency, into the single output FIFO. Each class receives up to `weight[i]` consecutive words per grant. The downstream `almost_full` provides backpressure. The block sits on the ingress side of the transaction layer, ahead of the class-routing arbiter.

## Interface
Parameters:
- `DATA_W`, 6: word width.
- `WEIGHT_W`, 3: width of each per-class weight and of the credit counter.
- `DEFAULT_WEIGHT`, 1: reset value of every weight.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: global enable. When low, no pop, `push` is cleared, and all other state holds.
- `fifo_empty`  in  4: empty flags of upstream FIFOs 0..3.
- `data_in`  in  4*DATA_W: head words of the first-word-fall-through upstream FIFOs. Queue i occupies bits `[i*DATA_W +: DATA_W]`.
- `almost_full`  in  1: almost-full flag of the downstream FIFO.
- `cfg_load`  in  1: when high, capture `cfg_weights` into the weight registers.
- `cfg_weights`  in  4*WEIGHT_W: new weights. Weight 0 masks that class.
- `pop`  out  4: one-hot combinational pop to the upstream FIFOs.
- `push`  out  1: registered push to the downstream FIFO.
- `data_out`  out  DATA_W: registered word to the downstream FIFO.
- `grant_id`  out  2: currently granted class.
- `busy`  out  1: high when state = SERVE.

## Operation
- FSM states: IDLE, SERVE. Registers: `state`, `gnt`, `ptr` (round-robin start), `credit`, `weight[0..3]`.
- Eligibility: queue i is eligible when `!fifo_empty[i] && weight[i] != 0`.
- **IDLE** (with `enable`): search eligible queues starting at `ptr` and wrapping modulo 4.
  - On a hit: `gnt`←hit, `credit`←`weight[hit]`, go to SERVE.
  - No pop occurs in IDLE (one-cycle arbitration bubble).
  - No hit: stay in IDLE.
- **SERVE**: `pop[gnt] = enable && !almost_full && !fifo_empty[gnt]`. All other `pop` bits are 0.
  - On a pop, `credit` decrements.
  - Release to IDLE, with `ptr`←`gnt+1` (mod 4), when either of these holds:
    - pop with `credit == 1`; or
    - `fifo_empty[gnt]` is high while in SERVE.
  - `almost_full` high: hold state, no pop, `credit` unchanged.
- Datapath: each cycle with `enable`, `push`←`|pop` and `data_out`←`data_in[gnt]` when pop, else `data_out` holds.
- Config:
  - `cfg_load` is honored in any state and takes effect on the next grant.
  - The `credit` value already loaded is not modified.
  - `cfg_load` coinciding with an IDLE grant: the grant uses the old weight.
- `grant_id` = `gnt`. It holds its last value in IDLE.
- Reset values: `state`=IDLE, `gnt`=0, `ptr`=0, `credit`=0, `weight[i]`=`DEFAULT_WEIGHT`, `push`=0, `data_out`=0. Hence `pop`=0, `busy`=0, `grant_id`=0.
- Reset has priority over `enable` and `cfg_load`. Reset asserted mid-SERVE abandons the grant. No push follows a pop cycle that is cut by reset.

## Timing
- Pop in cycle t → `push`=1 and `data_out`=popped word in cycle t+1. Latency is 1.
- Grant from IDLE to first pop: 1 cycle. Back-to-back grants cost 1 bubble cycle between classes.
- `almost_full` acts combinationally: a rise in cycle t blocks the pop in cycle t. Up to one word already in flight is still pushed in t+1. The downstream FIFO's almost-full threshold must leave ≥1 free slot.
- Sustained throughput with weight w and a continuously non-empty queue: w words per w+1 cycles.

## Structure
- Shared package: `NUM_Q`=4, state encoding (IDLE=0, SERVE=1), queue-index width (2).
- Sub-module `selector_rr`: combinational rotating priority picker.
  - Inputs: 4-bit eligible mask, 2-bit `ptr`.
  - Outputs: `hit` flag, 2-bit index.
- FSM, credit counter, config registers and output registers live in the top module.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with all queues non-empty → `pop`=0, `push`=0, `data_out`=0, `busy`=0; `weight` reads back as 1 via the grant pattern 0,1,2,3.
- Weights {3,1,2,1}, all queues holding 8 words → pop order 0,0,0,|1,|2,2,|3,|0,…. Exactly one bubble cycle between grants.
- Queue 2 with weight 4 holds 2 words → 2 pops, then release on empty and `ptr`=3. Next grant goes to queue 3 if it is eligible.
- `almost_full` held high for 5 cycles mid-SERVE with credit=2 → no pop during those cycles, `credit` stays at 2, and 2 pops follow deassertion.
- Weights {0,2,0,2} → queues 0 and 2 are never popped, even when non-empty. `cfg_load` to {1,2,0,2} while queue 1 is granted → the current credit is unchanged; queue 0 is served on its next turn.
- Pop word 0x2A from queue 1 in cycle t → `push`=1 and `data_out`=0x2A in t+1. Assert `reset` in t+1 → all outputs are zero in t+2.

Source files
------------

// File: rtl/arbitro_rr_pesos_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
package arbitro_rr_pesos_pkg;

  // Number of upstream class FIFOs and width of an index into them.
  localparam int unsigned NUM_Q  = 4;
  localparam int unsigned QIDX_W = 2;

  // Arbiter FSM: IDLE arbitrates, SERVE pops the granted queue.
  typedef enum logic {
    StIdle  = 1'b0,
    StServe = 1'b1
  } state_t;

  // Next queue index in round-robin order (wraps modulo NUM_Q).
  function automatic logic [QIDX_W-1:0] next_idx(input logic [QIDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/arbitro_rr_pesos_selector_rr.sv
// Rotating-priority picker: first eligible queue at or after the pointer, wrapping.
module arbitro_rr_pesos_selector_rr
  import arbitro_rr_pesos_pkg::*;
(
  input  logic [NUM_Q-1:0]  i_eligible,
  input  logic [QIDX_W-1:0] i_ptr,
  output logic              o_hit,
  output logic [QIDX_W-1:0] o_idx
);

  logic [QIDX_W-1:0] w_cand;

  // Scan the queues in rotated order and keep the first eligible one.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_cand = i_ptr;
    for (int k = 0; k < NUM_Q; k++) begin
      w_cand = i_ptr + QIDX_W'(k);
      if (!o_hit && i_eligible[w_cand]) begin
        o_hit = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_pesos.sv
// Weighted round-robin arbiter draining four class FIFOs into one downstream FIFO.
module arbitro_rr_pesos
  import arbitro_rr_pesos_pkg::*;
#(
  parameter int unsigned DATA_W         = 6,
  parameter int unsigned WEIGHT_W       = 3,
  parameter int unsigned DEFAULT_WEIGHT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_Q-1:0]          fifo_empty,
  input  logic [NUM_Q*DATA_W-1:0]   data_in,
  input  logic                      almost_full,
  input  logic                      cfg_load,
  input  logic [NUM_Q*WEIGHT_W-1:0] cfg_weights,
  output logic [NUM_Q-1:0]          pop,
  output logic                      push,
  output logic [DATA_W-1:0]         data_out,
  output logic [QIDX_W-1:0]         grant_id,
  output logic                      busy
);

  state_t              r_state;
  logic [QIDX_W-1:0]   r_gnt;
  logic [QIDX_W-1:0]   r_ptr;
  logic [WEIGHT_W-1:0] r_credit;
  logic [WEIGHT_W-1:0] r_weight [NUM_Q];
  logic                r_push;
  logic [DATA_W-1:0]   r_data_out;

  logic [DATA_W-1:0]   w_data [NUM_Q];
  logic [NUM_Q-1:0]    w_eligible;
  logic                w_hit;
  logic [QIDX_W-1:0]   w_hit_idx;
  logic                w_gnt_empty;
  logic                w_pop_ok;
  logic                w_last_credit;

  // Unpack the head words and flag queues that have data and a nonzero weight.
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      w_data[i]     = data_in[i*DATA_W +: DATA_W];
      w_eligible[i] = !fifo_empty[i] && (r_weight[i] != '0);
    end
  end

  arbitro_rr_pesos_selector_rr u_selector_rr (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_hit      (w_hit),
    .o_idx      (w_hit_idx)
  );

  assign w_gnt_empty   = fifo_empty[r_gnt];
  assign w_last_credit = (r_credit == WEIGHT_W'(1));
  // Reset gates the pop so a word is never taken from upstream and then dropped.
  assign w_pop_ok      = !reset && enable && (r_state == StServe) && !almost_full && !w_gnt_empty;

  // One-hot pop towards the granted upstream FIFO.
  always_comb begin
    pop        = '0;
    pop[r_gnt] = w_pop_ok;
  end

  // Arbitration FSM, credit counter, round-robin pointer and registered push/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_credit   <= '0;
      r_push     <= 1'b0;
      r_data_out <= '0;
    end else if (enable) begin
      r_push <= w_pop_ok;
      if (w_pop_ok) begin
        r_data_out <= w_data[r_gnt];
      end
      unique case (r_state)
        StIdle: begin
          // Grant uses the weight held before any cfg_load in this same cycle.
          if (w_hit) begin
            r_gnt    <= w_hit_idx;
            r_credit <= r_weight[w_hit_idx];
            r_state  <= StServe;
          end
        end
        StServe: begin
          if (w_pop_ok) begin
            r_credit <= r_credit - 1'b1;
          end
          if ((w_pop_ok && w_last_credit) || w_gnt_empty) begin
            r_state <= StIdle;
            r_ptr   <= next_idx(r_gnt);
          end
        end
        default: r_state <= StIdle;
      endcase
    end else begin
      r_push <= 1'b0;
    end
  end

  // Weight registers; new values only affect grants made after the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_Q; i++) begin
        r_weight[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
      end
    end else if (cfg_load) begin
      for (int i = 0; i < NUM_Q; i++) begin
        r_weight[i] <= cfg_weights[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  assign push     = r_push;
  assign data_out = r_data_out;
  assign grant_id = r_gnt;
  assign busy     = (r_state == StServe);

endmodule

// File: tb/tb_arbitro_rr_pesos.sv
// Self-checking bench: behavioural arbiter model plus directed literal sequences.
module tb_arbitro_rr_pesos;

  localparam int DW = 6;
  localparam int WW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [3:0]      fifo_empty = 4'hF;
  logic [4*DW-1:0] data_in = '0;
  logic            almost_full = 1'b0;
  logic            cfg_load = 1'b0;
  logic [4*WW-1:0] cfg_weights = '0;
  logic [3:0]      pop;
  logic            push;
  logic [DW-1:0]   data_out;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  arbitro_rr_pesos #(
    .DATA_W         (DW),
    .WEIGHT_W       (WW),
    .DEFAULT_WEIGHT (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .data_in     (data_in),
    .almost_full (almost_full),
    .cfg_load    (cfg_load),
    .cfg_weights (cfg_weights),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  // Upstream FIFO contents as seen by the bench.
  logic [DW-1:0] q[4][$];

  // Behavioural model: who is being served, words left in the turn, next start.
  bit            m_serving = 0;
  int            m_cls = 0;
  int            m_left = 0;
  int            m_ptr = 0;
  int            m_w[4] = '{1, 1, 1, 1};
  bit            m_push = 0;
  logic [DW-1:0] m_dout = '0;

  logic [3:0]    e_pop;
  logic          e_push;
  logic [DW-1:0] e_dout;
  logic [1:0]    e_gnt;
  logic          e_busy;

  int            n_checks = 0;
  int            n_fail = 0;
  bit            chk_on = 0;

  int            got_idx;
  logic          got_push;
  logic [DW-1:0] got_dout;
  logic [1:0]    got_gnt;
  logic          got_busy;

  // Hand-derived pop index per cycle (-1 = no pop).
  int e1[16] = '{-1, 0, -1, 1, -1, 2, -1, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  int e2[16] = '{-1, 0, 0, 0, -1, 1, -1, 2, 2, -1, 3, -1, 0, 0, 0, 0};
  int e3[16] = '{-1, 2, 2, -1, -1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int e4[16] = '{-1, 0, 0, -1, -1, -1, -1, -1, 0, 0, -1, 0, 0, 0, 0, 0};
  int e5[16] = '{-1, 1, 1, -1, 3, 3, -1, 1, 1, -1, 3, 3, -1, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [4*WW-1:0] pack_w(input int w0, input int w1, input int w2,
                                              input int w3);
    return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endfunction

  task automatic fill(input int i, input int n);
    for (int k = 0; k < n; k++) q[i].push_back(DW'($urandom));
  endtask

  // Expected outputs for the current cycle from model state and current inputs.
  task automatic compute_expect();
    e_pop = '0;
    if (!reset && m_serving && enable && !almost_full && q[m_cls].size() != 0)
      e_pop[m_cls] = 1'b1;
    e_push = m_push;
    e_dout = m_dout;
    e_gnt  = 2'(m_cls);
    e_busy = m_serving;
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_update();
    int  old_w[4];
    bit  popped;
    bit  was_empty;
    if (reset) begin
      m_serving = 0; m_cls = 0; m_left = 0; m_ptr = 0;
      m_w = '{1, 1, 1, 1};
      m_push = 0; m_dout = '0;
      return;
    end
    old_w = m_w;
    if (cfg_load) for (int i = 0; i < 4; i++) m_w[i] = int'(cfg_weights[i*WW +: WW]);
    if (!enable) begin
      m_push = 0;
      return;
    end
    popped    = (e_pop != 4'b0);
    was_empty = (q[m_cls].size() == 0);
    m_push    = popped;
    if (popped) m_dout = q[m_cls].pop_front();
    if (!m_serving) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (q[c].size() != 0 && old_w[c] != 0) begin
          m_serving = 1; m_cls = c; m_left = old_w[c];
          break;
        end
      end
    end else if (popped) begin
      m_left--;
      if (m_left == 0) begin m_serving = 0; m_ptr = (m_cls + 1) % 4; end
    end else if (was_empty) begin
      m_serving = 0; m_ptr = (m_cls + 1) % 4;
    end
  endtask

  // One clock: drive FIFO view, predict, sample DUT, then advance the model.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]       = (q[i].size() == 0);
      data_in[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
    compute_expect();
    #3;
    got_idx = -1;
    for (int i = 0; i < 4; i++) if (pop[i]) got_idx = i;
    got_push = push; got_dout = data_out; got_gnt = grant_id; got_busy = busy;
    @(posedge clk);
    #1;
    model_update();
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      check("pop", 32'(pop), 32'(e_pop));
      check("push", 32'(push), 32'(e_push));
      check("data_out", 32'(data_out), 32'(e_dout));
      check("grant_id", 32'(grant_id), 32'(e_gnt));
      check("busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic setup(input logic [4*WW-1:0] w);
    for (int i = 0; i < 4; i++) q[i].delete();
    reset = 1; enable = 1; almost_full = 0; cfg_load = 0;
    tick(); tick();
    reset = 0; cfg_load = 1; cfg_weights = w;
    tick();
    cfg_load = 0;
  endtask

  initial begin
    // Reset with all queues loaded, then default weights give 0,1,2,3.
    for (int i = 0; i < 4; i++) fill(i, 8);
    reset = 1; enable = 1;
    tick();
    chk_on = 1;
    tick();
    check("rst_pop", 32'(got_idx), 32'(-1));
    check("rst_push", 32'(got_push), 32'(0));
    check("rst_dout", 32'(got_dout), 32'(0));
    check("rst_busy", 32'(got_busy), 32'(0));
    reset = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      check($sformatf("dflt_seq%0d", j), 32'(got_idx), 32'(e1[j]));
    end

    // Weights {3,1,2,1}.
    setup(pack_w(3, 1, 2, 1));
    for (int i = 0; i < 4; i++) fill(i, 8);
    for (int j = 0; j < 13; j++) begin
      tick();
      check($sformatf("w3121_seq%0d", j), 32'(got_idx), 32'(e2[j]));
    end

    // Queue 2 weight 4 with only 2 words: release on empty, next start is queue 3.
    setup(pack_w(1, 1, 4, 1));
    fill(2, 2);
    for (int j = 0; j < 6; j++) begin
      if (j == 4) begin fill(0, 2); fill(3, 2); end
      tick();
      check($sformatf("empty_rel_seq%0d", j), 32'(got_idx), 32'(e3[j]));
      if (j == 3) check("gnt_hold_idle", 32'(got_gnt), 32'(2));
      if (j == 5) check("gnt_next_q3", 32'(got_gnt), 32'(3));
    end

    // almost_full for 5 cycles with 2 credits left.
    setup(pack_w(4, 1, 1, 1));
    fill(0, 8);
    for (int j = 0; j < 11; j++) begin
      almost_full = (j >= 3 && j <= 7);
      tick();
      check($sformatf("af_seq%0d", j), 32'(got_idx), 32'(e4[j]));
      if (j == 3) check("af_inflight_push", 32'(got_push), 32'(1));
      if (j == 4) check("af_no_push", 32'(got_push), 32'(0));
    end
    almost_full = 0;

    // Masked classes, then a reload while queue 1 is being served.
    setup(pack_w(0, 2, 0, 2));
    for (int i = 0; i < 4; i++) fill(i, 8);
    for (int j = 0; j < 14; j++) begin
      cfg_load = (j == 7);
      cfg_weights = pack_w(1, 2, 0, 2);
      tick();
      check($sformatf("mask_seq%0d", j), 32'(got_idx), 32'(e5[j]));
    end
    cfg_load = 0;

    // Pop 0x2A, see it pushed one cycle later, then reset clears everything.
    setup(pack_w(1, 1, 1, 1));
    q[1].push_back(6'h2A);
    q[1].push_back(6'h11);
    tick();
    tick();
    check("pop_2a", 32'(got_idx), 32'(1));
    reset = 1;
    tick();
    check("push_2a", 32'(got_push), 32'(1));
    check("dout_2a", 32'(got_dout), 32'(6'h2A));
    reset = 0;
    tick();
    check("post_rst_push", 32'(got_push), 32'(0));
    check("post_rst_dout", 32'(got_dout), 32'(0));
    check("post_rst_busy", 32'(got_busy), 32'(0));
    check("post_rst_gnt", 32'(got_gnt), 32'(0));
    check("post_rst_pop", 32'(got_idx), 32'(-1));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      almost_full = ($urandom_range(0, 4) == 0);
      cfg_load    = ($urandom_range(0, 39) == 0);
      cfg_weights = (4*WW)'($urandom);
      for (int i = 0; i < 4; i++)
        if (q[i].size() < 8 && $urandom_range(0, 2) == 0) q[i].push_back(DW'($urandom));
      tick();
    end

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
